// File: rtl/i2s_tx.sv
// I2S master transmitter: generates BCLK/LRCK and shifts stereo PCM out MSB first with the I2S one-bit delay.
// Define I2S_TX_REPEAT_EN to resend the last loaded pair on underrun; otherwise an underrun frame is all zeros.
module i2s_tx #(
   parameter int DATA_W   = 16,
   parameter int SLOT_W   = 32,
   parameter int BCLK_DIV = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] in_left,
   input  logic signed [DATA_W-1:0] in_right,
   output logic                     bclk,
   output logic                     lrck,
   output logic                     dacdat,
   output logic                     frame_start,
   output logic                     underrun
);

   localparam int PW = $clog2(2*SLOT_W);
   localparam int DW = $clog2(BCLK_DIV+1);
`ifdef I2S_TX_REPEAT_EN
   localparam bit REPEAT = 1'b1;
`else
   localparam bit REPEAT = 1'b0;
`endif

   logic [DW-1:0]            r_div;
   logic                     r_bclk;
   logic                     r_lrck;
   logic                     r_dacdat;
   logic [PW-1:0]            r_pos;
   logic                     r_hold_full;
   logic                     r_in_ready;
   logic                     r_frame_start;
   logic                     r_underrun;
   logic signed [DATA_W-1:0] r_hold_l;
   logic signed [DATA_W-1:0] r_hold_r;
   logic signed [DATA_W-1:0] r_sh_l;
   logic signed [DATA_W-1:0] r_sh_r;

   logic                     w_wrap;
   logic                     w_fall;
   logic                     w_frame0;
   logic                     w_accept;
   logic                     w_right;
   logic [PW-1:0]            w_s;
   logic [PW-1:0]            w_idx;
   logic                     w_inslot;
   logic signed [DATA_W-1:0] w_ch;
   logic [DATA_W-1:0]        w_mask;
   logic                     w_bit;

   assign w_wrap   = (r_div == DW'(BCLK_DIV-1));
   assign w_fall   = w_wrap & r_bclk;
   assign w_frame0 = w_fall & (r_pos == '0);
   assign w_accept = in_valid & r_in_ready;

   // bit position within the current slot; slot bit s carries sample bit DATA_W-s
   assign w_right  = (r_pos >= PW'(SLOT_W));
   assign w_s      = w_right ? (r_pos - PW'(SLOT_W)) : r_pos;
   assign w_inslot = (w_s != '0) && (w_s <= PW'(DATA_W));
   assign w_idx    = PW'(DATA_W) - w_s;
   assign w_ch     = w_right ? r_sh_r : r_sh_l;
   assign w_mask   = DATA_W'(1) << w_idx;
   assign w_bit    = |(w_ch & w_mask);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_div         <= '0;
         r_bclk        <= 1'b0;
         r_lrck        <= 1'b1;
         r_dacdat      <= 1'b0;
         r_pos         <= '0;
         r_hold_full   <= 1'b0;
         r_in_ready    <= 1'b1;
         r_frame_start <= 1'b0;
         r_underrun    <= 1'b0;
         r_sh_l        <= '0;
         r_sh_r        <= '0;
      end else begin
         r_frame_start <= w_frame0;
         r_underrun    <= w_frame0 & ~r_hold_full;
         // ready drops on accept and stays low through the load edge
         r_in_ready    <= w_accept ? 1'b0 : ~r_hold_full;

         if (w_wrap) begin
            r_div  <= '0;
            r_bclk <= ~r_bclk;
         end else begin
            r_div  <= r_div + DW'(1);
         end

         if (w_fall) begin
            r_pos    <= (r_pos == PW'(2*SLOT_W-1)) ? '0 : r_pos + PW'(1);
            r_lrck   <= w_right;
            r_dacdat <= w_inslot & w_bit;
         end

         if (w_frame0) begin
            if (r_hold_full) begin
               r_sh_l      <= r_hold_l;
               r_sh_r      <= r_hold_r;
               r_hold_full <= 1'b0;
            end else if (!REPEAT) begin
               r_sh_l      <= '0;
               r_sh_r      <= '0;
            end
         end

         if (w_accept)
            r_hold_full <= 1'b1;
      end
   end

   // holding data is qualified by r_hold_full, so it needs no reset
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_hold_l <= in_left;
         r_hold_r <= in_right;
      end
   end

   assign in_ready    = r_in_ready;
   assign bclk        = r_bclk;
   assign lrck        = r_lrck;
   assign dacdat      = r_dacdat;
   assign frame_start = r_frame_start;
   assign underrun    = r_underrun;

endmodule

// File: tb/tb_i2s_tx.sv
// Testbench for i2s_tx: per-cycle reference model from edge-count arithmetic plus a BCLK-rise receiver.
module tb_i2s_tx;

   localparam int DW = 16;
   localparam int SW = 32;
   localparam int BD = 2;
`ifdef I2S_TX_REPEAT_EN
   localparam bit REPEAT = 1'b1;
`else
   localparam bit REPEAT = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [15:0] in_left = '0;
   logic [15:0] in_right = '0;
   logic        in_ready, bclk, lrck, dacdat, frame_start, underrun;

   i2s_tx #(.DATA_W(DW), .SLOT_W(SW), .BCLK_DIV(BD)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_left(in_left), .in_right(in_right), .bclk(bclk), .lrck(lrck),
      .dacdat(dacdat), .frame_start(frame_start), .underrun(underrun)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // reference model state
   int          m_n, m_p;
   bit          m_started, m_hold_full, m_ready;
   bit          m_bclk, m_lrck, m_dac, m_fs, m_ur;
   logic [15:0] m_hold_l, m_hold_r, m_cur_l, m_cur_r;

   // receiver / observation state
   logic [15:0] rx_word = '0, rx_last_l = '0, rx_last_r = '0;
   bit          prev_bclk = 1'b0;
   bit          last_acc = 1'b0;
   int          fs_cnt = 0, ur_cnt = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, m_n);
      end
   endtask

   task automatic model_reset();
      m_n = 0; m_p = 0; m_started = 0;
      m_hold_full = 0; m_ready = 1;
      m_bclk = 0; m_lrck = 1; m_dac = 0; m_fs = 0; m_ur = 0;
      m_cur_l = '0; m_cur_r = '0;
   endtask

   // One clock edge: advance the model with the inputs present at the edge, then compare.
   task automatic tick();
      bit          r_in, v_in, acc, rdy_next;
      logic [15:0] l_in, ri_in, ch;
      int          s;
      r_in = rst; v_in = in_valid; l_in = in_left; ri_in = in_right;
      @(posedge clk);
      #1;
      last_acc = 0;
      if (r_in) begin
         model_reset();
      end else begin
         m_n++;
         acc      = v_in & m_ready;
         rdy_next = acc ? 1'b0 : !m_hold_full;
         m_fs = 0; m_ur = 0;
         m_bclk = ((m_n / BD) % 2) == 1;
         if (m_n % (2*BD) == 0) begin
            m_p = (m_n / (2*BD) - 1) % (2*SW);
            m_started = 1;
            if (m_p == 0) begin
               m_fs = 1;
               if (m_hold_full) begin
                  m_cur_l = m_hold_l; m_cur_r = m_hold_r; m_hold_full = 0;
               end else begin
                  m_ur = 1;
                  if (!REPEAT) begin m_cur_l = '0; m_cur_r = '0; end
               end
            end
            m_lrck = (m_p >= SW);
            s  = m_p % SW;
            ch = (m_p >= SW) ? m_cur_r : m_cur_l;
            m_dac = (s >= 1 && s <= DW) ? ch[DW-s] : 1'b0;
         end
         if (acc) begin
            m_hold_l = l_in; m_hold_r = ri_in; m_hold_full = 1;
         end
         m_ready  = rdy_next;
         last_acc = acc;
      end
      chk("bclk", bclk, m_bclk);
      chk("lrck", lrck, m_lrck);
      chk("dacdat", dacdat, m_dac);
      chk("in_ready", in_ready, m_ready);
      chk("frame_start", frame_start, m_fs);
      chk("underrun", underrun, m_ur);
      fs_cnt += int'(frame_start);
      ur_cnt += int'(underrun);
      // receiver: sample dacdat on every BCLK rise and reassemble words
      if (!r_in && bclk && !prev_bclk && m_started) begin
         s = m_p % SW;
         if (s >= 1 && s <= DW) begin
            rx_word = {rx_word[14:0], dacdat};
            if (s == DW) begin
               if (m_p < SW) begin
                  chk("rx_left", rx_word, m_cur_l); rx_last_l = rx_word;
               end else begin
                  chk("rx_right", rx_word, m_cur_r); rx_last_r = rx_word;
               end
            end
         end
      end
      prev_bclk = bclk;
   endtask

   task automatic wait_acc(input string tag, output int cycles);
      cycles = 0;
      forever begin
         tick();
         cycles++;
         if (last_acc) break;
         if (cycles >= 600) begin chk(tag, 0, 1); break; end
      end
   endtask

   task automatic wait_fs(input string tag);
      int c = 0;
      forever begin
         tick();
         c++;
         if (frame_start) break;
         if (c >= 600) begin chk(tag, 0, 1); break; end
      end
   endtask

   task automatic wait_pos(input string tag, input int target);
      int c = 0;
      forever begin
         tick();
         c++;
         if (m_started && m_p == target && (m_n % (2*BD)) == 0) break;
         if (c >= 600) begin chk(tag, 0, 1); break; end
      end
   endtask

   initial begin
      int waited, u0;
      model_reset();

      // reset held with a pending sample: nothing may be accepted
      rst = 1; in_valid = 1; in_left = 16'h1234; in_right = 16'h5678;
      repeat (3) tick();
      chk("rst_ready", in_ready, 1);

      // data frame followed by an underrun frame
      rst = 0; in_left = 16'hA5C3; in_right = 16'h0001;
      tick();
      in_valid = 0;
      repeat (199) tick();
      chk("data_left", rx_last_l, 16'hA5C3);
      chk("data_right", rx_last_r, 16'h0001);
      chk("data_no_ur", ur_cnt, 0);
      chk("data_fs", fs_cnt, 1);
      repeat (256) tick();
      chk("ur_left", rx_last_l, REPEAT ? 16'hA5C3 : 16'h0000);
      chk("ur_right", rx_last_r, REPEAT ? 16'h0001 : 16'h0000);
      chk("ur_cnt", ur_cnt, 1);
      chk("ur_fs", fs_cnt, 2);

      // backpressure: second pair waits for the load edge
      in_valid = 1; in_left = 16'h1111; in_right = 16'h2222;
      wait_acc("bp_acc1_timeout", waited);
      in_left = 16'h3333; in_right = 16'h4444;
      wait_acc("bp_acc2_timeout", waited);
      in_valid = 0;
      chk("bp_waited", waited > 1, 1);
      repeat (200) tick();
      chk("bp1_left", rx_last_l, 16'h1111);
      chk("bp1_right", rx_last_r, 16'h2222);
      wait_fs("bp_fs_timeout");
      repeat (200) tick();
      chk("bp2_left", rx_last_l, 16'h3333);
      chk("bp2_right", rx_last_r, 16'h4444);

      // mid-frame reset with the holding register full
      wait_pos("mrst_p1_timeout", 1);
      in_valid = 1; in_left = 16'h5555; in_right = 16'h6666;
      wait_acc("mrst_acc_timeout", waited);
      in_valid = 0;
      wait_pos("mrst_p20_timeout", 20);
      rst = 1;
      tick();
      chk("mrst_bclk", bclk, 0);
      chk("mrst_lrck", lrck, 1);
      chk("mrst_ready", in_ready, 1);
      rst = 0;
      u0 = ur_cnt;
      repeat (200) tick();
      chk("mrst_ur", ur_cnt - u0, 1);
      chk("mrst_left", rx_last_l, 16'h0000);
      chk("mrst_right", rx_last_r, 16'h0000);

      // randomized traffic with occasional resets
      repeat (4000) begin
         in_valid = ($urandom % 3) == 0;
         in_left  = 16'($urandom);
         in_right = 16'($urandom);
         rst      = ($urandom % 900) == 0;
         tick();
      end
      rst = 0; in_valid = 0;
      repeat (4) tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/i2s_tx.md
# i2s_tx

Audio serial transmitter for the DAC side of the codec link. Accepts stereo PCM samples through a valid/ready handshake and generates the bit clock, the left/right frame clock and serial data in I2S format. The block acts as clock master. Its edges are intended to be consumed by the team's one-cycle edge-detector strobes on the receive end.

## Interface
Parameters:
- DATA_W, 16: sample width per channel.
- SLOT_W, 32: BCLK periods per channel slot. Must satisfy SLOT_W ≥ DATA_W+1.
- BCLK_DIV, 4: clk cycles per BCLK half-period. Must be ≥ 1.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  sample pair present.
- in_ready  out  1  holding register empty.
- in_left  in  DATA_W  left sample, two's complement.
- in_right  in  DATA_W  right sample, two's complement.
- bclk  out  1  bit clock.
- lrck  out  1  frame clock; 0 = left slot, 1 = right slot.
- dacdat  out  1  serial data, MSB first.
- frame_start  out  1  one-cycle pulse at each frame boundary.
- underrun  out  1  one-cycle pulse when a frame starts with no sample.

## Operation
- Reset values, on the edge where rst=1: bclk=0, lrck=1, dacdat=0, in_ready=1, frame_start=0, underrun=0. The holding register is emptied, and all counters and shift data are cleared.
- Reset asserted mid-frame behaves identically: the next edge returns every output to its reset value and discards any held sample.
- Divider: a counter runs 0..BCLK_DIV-1. On wrap, bclk toggles.
- Fall event: a cycle in which bclk toggles 1→0. All updates to lrck and dacdat happen only on fall events.
- Position counter p runs 0..2·SLOT_W-1. It increments on every fall event and wraps to 0. Within a slot, s = p mod SLOT_W.
- On each fall event:
  - lrck = (p ≥ SLOT_W).
  - dacdat = sample bit [DATA_W-s] of the current channel for 1 ≤ s ≤ DATA_W, otherwise 0. This gives the I2S one-bit delay after each LRCK edge.
- On the fall event with p=0:
  - frame_start pulses.
  - If the holding register is full, its contents move to the left/right shift registers and the holding register empties.
  - If the holding register is empty, underrun pulses and the frame transmits the underrun payload (see Configuration).
- Handshake:
  - A sample is accepted on an edge where in_valid & in_ready.
  - in_ready = ~hold_full, registered.
  - On the p=0 load edge in_ready is still 0. It rises on the following edge, so accept and load never coincide.
  - in_left and in_right may change freely while in_ready=0.

## Timing
- Edge n = the n-th posedge after rst deasserts (the first is n=1).
- bclk rises after edge BCLK_DIV·(2k+1) and falls after edge BCLK_DIV·(2k+2), for k ≥ 0.
- BCLK period is 2·BCLK_DIV clk.
- Frame period is 2·SLOT_W BCLK periods.
- The first fall event (edge 2·BCLK_DIV) is p=0. There, lrck falls from its reset value 1, giving the receiver a frame edge on the first frame.
- A receiver samples dacdat on bclk rising edges. Data is stable for BCLK_DIV clk on either side of each rise.
- Accept-to-first-bit latency: the sample loads at the next p=0 event. Its MSB appears at the following fall event (p=1).

## Configuration
- I2S_TX_REPEAT_EN defined: on underrun, the most recently loaded sample pair is retransmitted. After reset that pair is 0.
- I2S_TX_REPEAT_EN undefined: on underrun, both slots transmit all zeros.
- In both cases the underrun pulse is identical.

## Test plan
All scenarios use DATA_W=16, SLOT_W=32, BCLK_DIV=2.
- Reset: hold rst=1 for 3 cycles with in_valid=1 → bclk=0, lrck=1, dacdat=0, in_ready=1, underrun=0, and no sample accepted.
- Clocking: release rst, idle → bclk rises after edge 2 and falls after edge 4 (period 4 clk); lrck falls after edge 4; lrck rises after edge 132 (p=32); frame_start pulses every 256 clk.
- Data: push L=16'hA5C3, R=16'h0001 on edge 1 → bits sampled at bclk rises for p=1..16 read A5C3 MSB-first; p=17..31 read 0; p=33..48 read 0001; frame_start is seen with underrun=0.
- Underrun: no push before the second frame → underrun pulses at the p=0 event. Without the macro all data bits are 0; with I2S_TX_REPEAT_EN the frame repeats A5C3/0001.
- Backpressure: push two pairs back to back → the second waits with in_ready=0 until the p=0 load edge; in_ready=1 one edge later; the pair is accepted and transmitted in the next frame.
- Mid-frame reset: assert rst at p=20 with the holding register full → outputs return to reset values on the next edge; after release, the first frame underruns.
